// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive FIFO behind a UART byte strobe, with overflow flag and level irq
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int THRESH = 8
) (
  input  logic                     sysclk,
  input  logic                     reset,
  input  logic                     rx_status,
  input  logic [7:0]               rx_data,
  input  logic                     rd_en,
  input  logic                     clr_ovf,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rx_q;
  logic          push_pend;
  logic [7:0]    push_data;
  logic          rise;
  logic          pop;
  logic          do_push;
  logic          drop;
  logic [CW-1:0] count_n;

  // The byte is captured on the edge-detect cycle and written one cycle later,
  // so a late change of rx_data cannot corrupt it.
  always_comb begin
    rise    = rx_status & ~rx_q;
    pop     = rd_en & ~empty;
    do_push = push_pend & (~full | pop);
    drop    = push_pend & full & ~pop;
    count_n = count + CW'(do_push) - CW'(pop);
  end

  always_ff @(posedge sysclk) begin
    if (rise) push_data <= rx_data;
    if (do_push && !reset) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_q      <= 1'b0;
      push_pend <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      irq       <= 1'b0;
      overflow  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= 8'h00;
    end else begin
      rx_q      <= rx_status;
      push_pend <= rise;
      rd_valid  <= pop;
      if (pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
      end
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      count <= count_n;
      empty <= (count_n == '0);
      full  <= (count_n == CW'(DEPTH));
      irq   <= (count_n >= CW'(THRESH));
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule
